// File: rtl/sevenseg_pkg.sv
// ============================================================================
// Module : sevenseg_pkg
// Shared 7-segment pattern constants ({A..G}, active low) and reader FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sevenseg_pkg;

   localparam logic [6:0] PAT_0 = 7'b0000001;
   localparam logic [6:0] PAT_1 = 7'b1001111;
   localparam logic [6:0] PAT_2 = 7'b0010010;
   localparam logic [6:0] PAT_3 = 7'b0000110;
   localparam logic [6:0] PAT_4 = 7'b1001100;
   localparam logic [6:0] PAT_5 = 7'b0100100;
   localparam logic [6:0] PAT_6 = 7'b1100000;
   localparam logic [6:0] PAT_7 = 7'b0001111;
   localparam logic [6:0] PAT_8 = 7'b0000000;
   localparam logic [6:0] PAT_9 = 7'b0001100;
   localparam logic [6:0] PAT_A = 7'b0001000;
   // Hex b is drawn identically to 6, so it can never be told apart on the bus.
   localparam logic [6:0] PAT_B = 7'b1100000;
   localparam logic [6:0] PAT_C = 7'b0110001;
   localparam logic [6:0] PAT_D = 7'b1000010;
   localparam logic [6:0] PAT_E = 7'b0110000;
   localparam logic [6:0] PAT_F = 7'b0111000;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/seg_pattern_decode.sv
// ============================================================================
// Module : seg_pattern_decode
// Combinational 7-segment pattern -> {err, code}; hex letters when
// SEVENSEG_READER_HEX_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_pattern_decode
   import sevenseg_pkg::*;
(
   input  logic [6:0] pat_i,
   output logic [3:0] code_o,
   output logic       err_o
);

   always_comb begin
      code_o = 4'h0;
      err_o  = 1'b0;
      case (pat_i)
         PAT_0:   code_o = 4'h0;
         PAT_1:   code_o = 4'h1;
         PAT_2:   code_o = 4'h2;
         PAT_3:   code_o = 4'h3;
         PAT_4:   code_o = 4'h4;
         PAT_5:   code_o = 4'h5;
         PAT_6:   code_o = 4'h6;
         PAT_7:   code_o = 4'h7;
         PAT_8:   code_o = 4'h8;
         PAT_9:   code_o = 4'h9;
`ifdef SEVENSEG_READER_HEX_EN
         PAT_A:   code_o = 4'hA;
         PAT_C:   code_o = 4'hC;
         PAT_D:   code_o = 4'hD;
         PAT_E:   code_o = 4'hE;
         PAT_F:   code_o = 4'hF;
`else
`endif
         default: err_o  = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/sevenseg_reader.sv
// ============================================================================
// Module : sevenseg_reader
// Sniffs a multiplexed active-low 7-segment bus and emits one frame of BCD
// digits per complete scan. Optional hex letters: SEVENSEG_READER_HEX_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sevenseg_reader
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] frame_digits,
   output logic [NUM_DIGITS-1:0]   frame_err,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic                    overrun
);

   localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

   logic [6:0]              seg_meta_q, seg_sync_q;
   logic [NUM_DIGITS-1:0]   an_meta_q, an_sync_q;
   logic [1:0]              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [6:0]              pat_q, pat_d;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
   logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
   logic [4*NUM_DIGITS-1:0] frame_dig_q, frame_dig_d;
   logic [NUM_DIGITS-1:0]   frame_err_q, frame_err_d;
   logic                    valid_q, valid_d;
   logic                    overrun_q, overrun_d;

   logic [NUM_DIGITS-1:0]   an_low;
   logic                    one_low;
   logic [IDX_W-1:0]        low_idx;
   logic [3:0]              dec_code;
   logic                    dec_err;
   logic                    capture;
   logic                    complete;

   assign an_low   = ~an_sync_q;
   assign one_low  = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
   assign complete = (seen_q == ALL_SEEN);

   always_comb begin
      low_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (an_low[i]) low_idx = IDX_W'(i);
      end
   end

   seg_pattern_decode u_decode (
      .pat_i  (seg_sync_q),
      .code_o (dec_code),
      .err_o  (dec_err)
   );

   // Any disturbance before the settle count completes drops back to IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      pat_d   = pat_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (one_low) begin
               idx_d = low_idx;
               pat_d = seg_sync_q;
               cnt_d = CNT_W'(1);
               if (SETTLE_CYCLES == 1) begin
                  capture = 1'b1;
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (one_low && (low_idx == idx_q) && (seg_sync_q == pat_q)) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(SETTLE_CYCLES)) begin
                  capture = 1'b1;
                  state_d = ST_HOLD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (!(one_low && (low_idx == idx_q))) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      seen_d       = complete ? '0 : seen_q;
      shadow_dig_d = shadow_dig_q;
      shadow_err_d = shadow_err_q;
      if (capture) begin
         seen_d[low_idx]                  = 1'b1;
         shadow_dig_d[{low_idx, 2'b00} +: 4] = dec_code;
         shadow_err_d[low_idx]            = dec_err;
      end
      frame_dig_d = frame_dig_q;
      frame_err_d = frame_err_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      // A completing frame always loads; it only overruns if the old one was left unaccepted.
      if (complete) begin
         frame_dig_d = shadow_dig_q;
         frame_err_d = shadow_err_q;
         valid_d     = 1'b1;
         if (valid_q && !frame_ready) overrun_d = 1'b1;
      end else if (valid_q && frame_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_meta_q   <= '0;
         seg_sync_q   <= '0;
         an_meta_q    <= '0;
         an_sync_q    <= '0;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         pat_q        <= '0;
         seen_q       <= '0;
         shadow_dig_q <= '0;
         shadow_err_q <= '0;
         frame_dig_q  <= '0;
         frame_err_q  <= '0;
         valid_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         seg_meta_q   <= seg_n;
         seg_sync_q   <= seg_meta_q;
         an_meta_q    <= an_n;
         an_sync_q    <= an_meta_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pat_q        <= pat_d;
         seen_q       <= seen_d;
         shadow_dig_q <= shadow_dig_d;
         shadow_err_q <= shadow_err_d;
         frame_dig_q  <= frame_dig_d;
         frame_err_q  <= frame_err_d;
         valid_q      <= valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign frame_digits = frame_dig_q;
   assign frame_err    = frame_err_q;
   assign frame_valid  = valid_q;
   assign overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_reader.sv
// ============================================================================
// Module : tb_sevenseg_reader
// Self-checking bench for sevenseg_reader (NUM_DIGITS=4, SETTLE_CYCLES=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sevenseg_reader;

   localparam int ND = 4;
   localparam int ST = 4;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S6 = 7'b1100000;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0001100;
   localparam logic [6:0] SE = 7'b0110000;
   localparam logic [6:0] SBAD = 7'b1111110;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [6:0]      seg_n = 7'h7f;
   logic [ND-1:0]   an_n = '1;
   logic            frame_ready = 1'b0;
   logic [4*ND-1:0] frame_digits;
   logic [ND-1:0]   frame_err;
   logic            frame_valid;
   logic            overrun;

   int checks = 0;
   int failures = 0;

   logic [6:0] legal [10] = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};
   logic [6:0] hex_pat [5] = '{7'b0001000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
   logic [3:0] hex_code [5] = '{4'hA, 4'hC, 4'hD, 4'hE, 4'hF};

   typedef struct packed {
      logic [ND-1:0][6:0] pat;
      logic [15:0]        dig;
      logic [3:0]         err;
   } vec_t;

   vec_t vecs [5];

   always #5 clk = ~clk;

   sevenseg_reader #(.NUM_DIGITS(ND), .SETTLE_CYCLES(ST)) dut (
      .clk          (clk),
      .reset        (reset),
      .seg_n        (seg_n),
      .an_n         (an_n),
      .frame_digits (frame_digits),
      .frame_err    (frame_err),
      .frame_valid  (frame_valid),
      .frame_ready  (frame_ready),
      .overrun      (overrun)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1);
   end

   // Reference decode: table lookup over the legal glyph list.
   function automatic logic [4:0] model_decode(input logic [6:0] p);
      for (int i = 0; i < 10; i++) if (p == legal[i]) return {1'b0, 4'(i)};
`ifdef SEVENSEG_READER_HEX_EN
      for (int j = 0; j < 5; j++) if (p == hex_pat[j]) return {1'b0, hex_code[j]};
`endif
      return 5'h10;
   endfunction

   function automatic vec_t mk(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                               input logic [6:0] p3, input logic [15:0] d, input logic [3:0] e);
      vec_t v;
      v.pat[0] = p0;
      v.pat[1] = p1;
      v.pat[2] = p2;
      v.pat[3] = p3;
      v.dig    = d;
      v.err    = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic show(input int d, input logic [6:0] p, input int n);
      an_n    = '1;
      an_n[d] = 1'b0;
      seg_n   = p;
      tick(n);
      an_n  = '1;
      seg_n = 7'h7f;
      tick(1);
   endtask

   task automatic scan_frame(input vec_t v);
      for (int d = 0; d < ND; d++) show(d, v.pat[d], 10);
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      while (!frame_valid && k < 40) begin
         tick(1);
         k++;
      end
      check({name, "_valid"}, 32'(frame_valid), 32'd1);
   endtask

   task automatic accept(input string name);
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      check({name, "_accept"}, 32'(frame_valid), 32'd0);
   endtask

   logic [3:0]  m_seen;
   logic [15:0] m_dig;
   logic [3:0]  m_err;
   logic [4:0]  m_dec;
   logic [6:0]  rp;
   int          rd, rn, guard;

   initial begin
      vecs[0] = mk(S1, S2, S3, S4, 16'h4321, 4'b0000);
      vecs[1] = mk(S0, S9, S8, S7, 16'h7890, 4'b0000);
      vecs[2] = mk(S5, SBAD, S6, S0, 16'h0605, 4'b0010);
`ifdef SEVENSEG_READER_HEX_EN
      vecs[3] = mk(SE, S2, S2, S2, 16'h222E, 4'b0000);
`else
      vecs[3] = mk(SE, S2, S2, S2, 16'h2220, 4'b0001);
`endif
      vecs[4] = mk(7'h7f, S8, S1, S5, 16'h5180, 4'b0001);

      tick(3);
      check("reset_outputs", {10'd0, overrun, frame_valid, frame_err, frame_digits}, 32'd0);
      reset = 1'b0;
      tick(30);
      check("idle_no_frame", 32'(frame_valid), 32'd0);

      for (int i = 0; i < 5; i++) begin
         scan_frame(vecs[i]);
         wait_valid($sformatf("vec%0d", i));
         check($sformatf("vec%0d_digits", i), 32'(frame_digits), 32'(vecs[i].dig));
         check($sformatf("vec%0d_err", i), 32'(frame_err), 32'(vecs[i].err));
         tick(5);
         check($sformatf("vec%0d_stable", i), {frame_err, frame_digits, 11'd0, frame_valid},
               {vecs[i].err, vecs[i].dig, 11'd0, 1'b1});
         accept($sformatf("vec%0d", i));
      end

      // Short glitch of 3 on digit 2 before a steady 7.
      show(0, S1, 10);
      show(1, S2, 10);
      an_n  = 4'b1011;
      seg_n = S3;
      tick(2);
      seg_n = S7;
      tick(10);
      an_n  = '1;
      tick(1);
      show(3, S4, 10);
      wait_valid("glitch");
      check("glitch_digits", 32'(frame_digits), 32'h4721);
      accept("glitch");

      // Hold one cycle short of settle, then exactly settle.
      show(0, S3, 10);
      show(1, S6, 10);
      show(2, S9, 10);
      show(3, S5, ST - 1);
      tick(20);
      check("short_hold_no_frame", 32'(frame_valid), 32'd0);
      show(3, S5, ST);
      wait_valid("exact_hold");
      check("exact_hold_digits", 32'(frame_digits), 32'h5963);
      accept("exact_hold");

      // Two anodes low must not capture anything.
      show(0, S1, 10);
      show(1, S2, 10);
      show(2, S3, 10);
      an_n  = 4'b0011;
      seg_n = S8;
      tick(10);
      an_n  = '1;
      tick(20);
      check("two_anodes_no_frame", 32'(frame_valid), 32'd0);
      show(3, S9, 10);
      wait_valid("two_anodes");
      check("two_anodes_digits", 32'(frame_digits), 32'h9321);
      accept("two_anodes");

      // Accept lands on the same cycle the next frame completes.
      scan_frame(vecs[0]);
      wait_valid("sim_first");
      show(0, S7, 10);
      show(1, S7, 10);
      show(2, S7, 10);
      an_n  = 4'b0111;
      seg_n = S6;
      tick(6);
      frame_ready = 1'b1;
      tick(1);
      frame_ready = 1'b0;
      check("sim_valid_overrun", {30'd0, frame_valid, overrun}, 32'b10);
      check("sim_digits", 32'(frame_digits), 32'h6777);
      tick(3);
      an_n  = '1;
      tick(1);

      // Unaccepted frame gets overwritten.
      scan_frame(vecs[1]);
      tick(3);
      check("overrun_set", {30'd0, frame_valid, overrun}, 32'b11);
      check("overrun_digits", 32'(frame_digits), 32'h7890);

      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("midclk_reset", {10'd0, overrun, frame_valid, frame_err, frame_digits}, 32'd0);
      tick(2);
      reset = 1'b0;
      tick(20);
      check("post_reset_idle", {30'd0, frame_valid, overrun}, 32'd0);

      // Partial frame discarded by reset.
      show(0, S1, 10);
      show(1, S2, 10);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      show(1, S4, 10);
      show(2, S4, 10);
      show(3, S4, 10);
      tick(20);
      check("reset_partial_dropped", 32'(frame_valid), 32'd0);
      show(0, S8, 10);
      wait_valid("after_partial");
      check("after_partial_digits", 32'(frame_digits), 32'h4448);
      accept("after_partial");

      // Random scans against the reference model.
      for (int f = 0; f < 15; f++) begin
         m_seen = '0;
         m_dig  = '0;
         m_err  = '0;
         guard  = 0;
         while (m_seen != 4'hf && guard < 200) begin
            rd = $urandom_range(0, 3);
            rn = $urandom_range(1, 10);
            if ($urandom_range(0, 1) == 1) rp = legal[$urandom_range(0, 9)];
            else                           rp = 7'($urandom);
            show(rd, rp, rn);
            if (rn >= ST) begin
               m_dec            = model_decode(rp);
               m_seen[rd]       = 1'b1;
               m_dig[4*rd +: 4] = m_dec[3:0];
               m_err[rd]        = m_dec[4];
            end
            guard++;
         end
         wait_valid($sformatf("rnd%0d", f));
         check($sformatf("rnd%0d_digits", f), 32'(frame_digits), 32'(m_dig));
         check($sformatf("rnd%0d_err", f), 32'(frame_err), 32'(m_err));
         accept($sformatf("rnd%0d", f));
      end
      check("final_no_overrun", 32'(overrun), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
